// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shifter types,
// operand-forwarding select encodings and the NZCV flag layout.
package exe_stage_pkg;

   localparam logic [3:0] ALU_MOV = 4'b0001;
   localparam logic [3:0] ALU_MVN = 4'b1001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_ADC = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SBC = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b0110;
   localparam logic [3:0] ALU_ORR = 4'b0111;
   localparam logic [3:0] ALU_EOR = 4'b1000;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
      logic [63:0] t;
      t = {x, x} >> n;
      return t[31:0];
   endfunction

endpackage

// File: rtl/val2_gen.sv
// Second-operand generator: memory offset, rotated immediate or shifted register.
// Purely combinational, no state and no flow control.
module val2_gen
   import exe_stage_pkg::*;
(
   input  logic [31:0] reg2,
   input  logic [11:0] shifter_operand,
   input  logic        I_in,
   input  logic        mem_rw,
   output logic [31:0] val2
);

   logic [4:0] sh_amt;

   always_comb begin
      sh_amt = shifter_operand[11:7];
      val2   = reg2;
      if (mem_rw) begin
         val2 = {20'b0, shifter_operand};
      end else if (I_in) begin
         // rotate field counts in pairs of bits
         val2 = ror32({24'b0, shifter_operand[7:0]}, {shifter_operand[11:8], 1'b0});
      end else begin
         case (shifter_operand[6:5])
            SH_LSL:  val2 = reg2 << sh_amt;
            SH_LSR:  val2 = reg2 >> sh_amt;
            SH_ASR:  val2 = $unsigned($signed(reg2) >>> sh_amt);
            default: val2 = ror32(reg2, sh_amt);
         endcase
      end
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV status register, branch target and EXE/MEM register (1-cycle).
// freeze holds every register; FORWARDING_EN adds mem/wb operand forwarding muxes.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic [31:0] pc_in,
   input  logic [31:0] reg1_in,
   input  logic [31:0] reg2_in,
   input  logic [3:0]  alu_cmd,
   input  logic        status_en,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        wb_en_in,
   input  logic        branch_in,
   input  logic        I_in,
   input  logic [3:0]  dest_in,
   input  logic [3:0]  status_in,
   input  logic [11:0] shifter_operand,
   input  logic [23:0] b_signed_imm,
`ifdef FORWARDING_EN
   input  logic [1:0]  sel_src1,
   input  logic [1:0]  sel_src2,
   input  logic [31:0] mem_fwd_val,
   input  logic [31:0] wb_fwd_val,
`endif
   output logic        branch_taken,
   output logic [31:0] branch_addr,
   output logic [3:0]  sr_out,
   output logic [31:0] alu_res_out,
   output logic [31:0] st_val_out,
   output logic [3:0]  dest_out,
   output logic        wb_en_out,
   output logic        mem_read_out,
   output logic        mem_write_out
);

   logic [31:0] src1, src2, val2, alu_res;
   logic [32:0] res33;
   nzcv_t       flags;
   logic        flag_upd, is_add, is_sub;
   logic        cin;

   nzcv_t       sr_q, sr_d;
   logic [31:0] alu_res_q, alu_res_d;
   logic [31:0] st_val_q, st_val_d;
   logic [3:0]  dest_q, dest_d;
   logic        wb_en_q, wb_en_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;

   // only the carry of the incoming flags feeds the ALU
   logic unused_status;
   assign unused_status = ^{status_in[3:2], status_in[0]};
   assign cin = status_in[1];

`ifdef FORWARDING_EN
   always_comb begin
      case (sel_src1)
         FWD_MEM: src1 = mem_fwd_val;
         FWD_WB:  src1 = wb_fwd_val;
         default: src1 = reg1_in;
      endcase
      case (sel_src2)
         FWD_MEM: src2 = mem_fwd_val;
         FWD_WB:  src2 = wb_fwd_val;
         default: src2 = reg2_in;
      endcase
   end
`else
   always_comb begin
      src1 = reg1_in;
      src2 = reg2_in;
   end
`endif

   val2_gen u_val2_gen (
      .reg2            (src2),
      .shifter_operand (shifter_operand),
      .I_in            (I_in),
      .mem_rw          (mem_read_in | mem_write_in),
      .val2            (val2)
   );

   always_comb begin
      res33    = '0;
      flag_upd = 1'b1;
      is_add   = 1'b0;
      is_sub   = 1'b0;
      case (alu_cmd)
         ALU_MOV: res33 = {1'b0, val2};
         ALU_MVN: res33 = {1'b0, ~val2};
         ALU_ADD: begin res33 = {1'b0, src1} + {1'b0, val2};                   is_add = 1'b1; end
         ALU_ADC: begin res33 = {1'b0, src1} + {1'b0, val2} + {32'b0, cin};    is_add = 1'b1; end
         ALU_SUB: begin res33 = {1'b0, src1} - {1'b0, val2};                   is_sub = 1'b1; end
         ALU_SBC: begin res33 = {1'b0, src1} - {1'b0, val2} - {32'b0, ~cin};   is_sub = 1'b1; end
         ALU_AND: res33 = {1'b0, src1 & val2};
         ALU_ORR: res33 = {1'b0, src1 | val2};
         ALU_EOR: res33 = {1'b0, src1 ^ val2};
         default: flag_upd = 1'b0;
      endcase
      alu_res = res33[31:0];
      flags.n = alu_res[31];
      flags.z = (alu_res == 32'b0);
      // bit 32 of a subtraction is the borrow, so carry is its inverse
      flags.c = (is_add & res33[32]) | (is_sub & ~res33[32]);
      flags.v = (is_add & (src1[31] == val2[31]) & (alu_res[31] != src1[31])) |
                (is_sub & (src1[31] != val2[31]) & (alu_res[31] != src1[31]));
   end

   always_comb begin
      sr_d        = sr_q;
      alu_res_d   = alu_res_q;
      st_val_d    = st_val_q;
      dest_d      = dest_q;
      wb_en_d     = wb_en_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      if (!freeze) begin
         if (status_en && flag_upd) sr_d = flags;
         alu_res_d   = alu_res;
         st_val_d    = src2;
         dest_d      = dest_in;
         wb_en_d     = wb_en_in;
         mem_read_d  = mem_read_in;
         mem_write_d = mem_write_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q        <= '0;
         alu_res_q   <= '0;
         st_val_q    <= '0;
         dest_q      <= '0;
         wb_en_q     <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         alu_res_q   <= alu_res_d;
         st_val_q    <= st_val_d;
         dest_q      <= dest_d;
         wb_en_q     <= wb_en_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   assign branch_taken  = branch_in;
   assign branch_addr   = pc_in + {{6{b_signed_imm[23]}}, b_signed_imm, 2'b00};
   assign sr_out        = sr_q;
   assign alu_res_out   = alu_res_q;
   assign st_val_out    = st_val_q;
   assign dest_out      = dest_q;
   assign wb_en_out     = wb_en_q;
   assign mem_read_out  = mem_read_q;
   assign mem_write_out = mem_write_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU, shifter, flags, freeze, branch, reset, forwarding.
module tb_exe_stage;
   import exe_stage_pkg::*;

   logic        clk, rst, freeze;
   logic [31:0] pc_in, reg1_in, reg2_in;
   logic [3:0]  alu_cmd;
   logic        status_en, mem_read_in, mem_write_in, wb_en_in, branch_in, I_in;
   logic [3:0]  dest_in, status_in;
   logic [11:0] shifter_operand;
   logic [23:0] b_signed_imm;
`ifdef FORWARDING_EN
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] mem_fwd_val, wb_fwd_val;
`endif
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [3:0]  sr_out;
   logic [31:0] alu_res_out, st_val_out;
   logic [3:0]  dest_out;
   logic        wb_en_out, mem_read_out, mem_write_out;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   exe_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
      .reg1_in(reg1_in), .reg2_in(reg2_in), .alu_cmd(alu_cmd),
      .status_en(status_en), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .wb_en_in(wb_en_in), .branch_in(branch_in), .I_in(I_in),
      .dest_in(dest_in), .status_in(status_in), .shifter_operand(shifter_operand),
      .b_signed_imm(b_signed_imm),
`ifdef FORWARDING_EN
      .sel_src1(sel_src1), .sel_src2(sel_src2),
      .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
`endif
      .branch_taken(branch_taken), .branch_addr(branch_addr), .sr_out(sr_out),
      .alu_res_out(alu_res_out), .st_val_out(st_val_out), .dest_out(dest_out),
      .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      freeze = 0; pc_in = 0; reg1_in = 0; reg2_in = 0; alu_cmd = 0;
      status_en = 0; mem_read_in = 0; mem_write_in = 0; wb_en_in = 0;
      branch_in = 0; I_in = 0; dest_in = 0; status_in = 0;
      shifter_operand = 0; b_signed_imm = 0;
`ifdef FORWARDING_EN
      sel_src1 = 0; sel_src2 = 0; mem_fwd_val = 0; wb_fwd_val = 0;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      #2;
      chk_cnt++; if (alu_res_out !== 32'h0) $display("FAIL rst_alu_res got %h exp 0", alu_res_out); else pass_cnt++;
      chk_cnt++; if (st_val_out !== 32'h0) $display("FAIL rst_st_val got %h exp 0", st_val_out); else pass_cnt++;
      chk_cnt++; if ({dest_out, wb_en_out, mem_read_out, mem_write_out} !== 7'h0)
         $display("FAIL rst_ctrl got %b exp 0", {dest_out, wb_en_out, mem_read_out, mem_write_out}); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'h0) $display("FAIL rst_sr got %b exp 0000", sr_out); else pass_cnt++;
      #1 rst = 1'b0;
   endtask

   task automatic test_add_overflow();
      clear_inputs();
      reg1_in = 32'h7FFF_FFFF; reg2_in = 32'h1; alu_cmd = ALU_ADD;
      status_en = 1; dest_in = 4'd3; wb_en_in = 1;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h8000_0000) $display("FAIL add_ovf_res got %h exp 80000000", alu_res_out); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'b1001) $display("FAIL add_ovf_sr got %b exp 1001", sr_out); else pass_cnt++;
      chk_cnt++; if (dest_out !== 4'd3 || wb_en_out !== 1'b1) $display("FAIL add_ovf_ctrl got %h/%b exp 3/1", dest_out, wb_en_out); else pass_cnt++;
      chk_cnt++; if (st_val_out !== 32'h1) $display("FAIL add_ovf_stval got %h exp 1", st_val_out); else pass_cnt++;
   endtask

   task automatic test_imm_rotate();
      clear_inputs();
      I_in = 1; shifter_operand = 12'h4FF; alu_cmd = ALU_MOV;
      tick();
      chk_cnt++; if (alu_res_out !== 32'hFF00_0000) $display("FAIL imm_rot_res got %h exp FF000000", alu_res_out); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'b1001) $display("FAIL imm_rot_sr_kept got %b exp 1001", sr_out); else pass_cnt++;
   endtask

   task automatic test_shifts();
      logic [11:0] ops [4];
      logic [31:0] exp [4];
      ops[0] = 12'h200; exp[0] = 32'h0000_0130;
      ops[1] = 12'h220; exp[1] = 32'h0800_0001;
      ops[2] = 12'h240; exp[2] = 32'hF800_0001;
      ops[3] = 12'h260; exp[3] = 32'h3800_0001;
      for (int i = 0; i < 4; i++) begin
         clear_inputs();
         reg2_in = 32'h8000_0013; alu_cmd = ALU_MOV; shifter_operand = ops[i];
         tick();
         chk_cnt++; if (alu_res_out !== exp[i]) $display("FAIL shift_%0d got %h exp %h", i, alu_res_out, exp[i]); else pass_cnt++;
      end
   endtask

   task automatic test_sub_freeze();
      clear_inputs();
      reg1_in = 5; reg2_in = 5; alu_cmd = ALU_SUB; status_en = 1; dest_in = 4'd2; wb_en_in = 1;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h0) $display("FAIL sub_res got %h exp 0", alu_res_out); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'b0110) $display("FAIL sub_sr got %b exp 0110", sr_out); else pass_cnt++;
      freeze = 1; reg1_in = 1; reg2_in = 1; alu_cmd = ALU_ADD; dest_in = 4'd9; wb_en_in = 0; mem_write_in = 1;
      tick();
      tick();
      chk_cnt++; if (alu_res_out !== 32'h0) $display("FAIL freeze_res got %h exp 0", alu_res_out); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'b0110) $display("FAIL freeze_sr got %b exp 0110", sr_out); else pass_cnt++;
      chk_cnt++; if (dest_out !== 4'd2 || wb_en_out !== 1'b1 || mem_write_out !== 1'b0)
         $display("FAIL freeze_ctrl got %h/%b/%b exp 2/1/0", dest_out, wb_en_out, mem_write_out); else pass_cnt++;
   endtask

   task automatic test_adc_sbc();
      clear_inputs();
      reg1_in = 1; reg2_in = 2; alu_cmd = ALU_ADC; status_in = 4'b0010;
      tick();
      chk_cnt++; if (alu_res_out !== 32'd4) $display("FAIL adc_res got %h exp 4", alu_res_out); else pass_cnt++;
      reg1_in = 10; reg2_in = 3; alu_cmd = ALU_SBC; status_in = 4'b0000;
      tick();
      chk_cnt++; if (alu_res_out !== 32'd6) $display("FAIL sbc_c0_res got %h exp 6", alu_res_out); else pass_cnt++;
      status_in = 4'b0010;
      tick();
      chk_cnt++; if (alu_res_out !== 32'd7) $display("FAIL sbc_c1_res got %h exp 7", alu_res_out); else pass_cnt++;
      status_in = 0; reg1_in = 3; reg2_in = 5; alu_cmd = ALU_SUB; status_en = 1;
      tick();
      chk_cnt++; if (alu_res_out !== 32'hFFFF_FFFE) $display("FAIL sub_borrow_res got %h exp FFFFFFFE", alu_res_out); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'b1000) $display("FAIL sub_borrow_sr got %b exp 1000", sr_out); else pass_cnt++;
      reg1_in = 32'hFFFF_FFFF; reg2_in = 1; alu_cmd = ALU_ADD;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h0) $display("FAIL add_carry_res got %h exp 0", alu_res_out); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'b0110) $display("FAIL add_carry_sr got %b exp 0110", sr_out); else pass_cnt++;
   endtask

   task automatic test_logic_ops();
      clear_inputs();
      reg1_in = 32'hF0F0_F0F0; reg2_in = 32'hFF00_FF00; alu_cmd = ALU_EOR; status_en = 1;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h0FF0_0FF0) $display("FAIL eor_res got %h exp 0FF00FF0", alu_res_out); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'b0000) $display("FAIL eor_sr got %b exp 0000", sr_out); else pass_cnt++;
      alu_cmd = ALU_AND;
      tick();
      chk_cnt++; if (alu_res_out !== 32'hF000_F000) $display("FAIL and_res got %h exp F000F000", alu_res_out); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'b1000) $display("FAIL and_sr got %b exp 1000", sr_out); else pass_cnt++;
      status_en = 0; alu_cmd = ALU_ORR;
      tick();
      chk_cnt++; if (alu_res_out !== 32'hFFF0_FFF0) $display("FAIL orr_res got %h exp FFF0FFF0", alu_res_out); else pass_cnt++;
      alu_cmd = ALU_MVN;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h00FF_00FF) $display("FAIL mvn_res got %h exp 00FF00FF", alu_res_out); else pass_cnt++;
      alu_cmd = 4'b1111; status_en = 1;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h0) $display("FAIL undef_res got %h exp 0", alu_res_out); else pass_cnt++;
      chk_cnt++; if (sr_out !== 4'b1000) $display("FAIL undef_sr got %b exp 1000", sr_out); else pass_cnt++;
   endtask

   task automatic test_mem_addr();
      clear_inputs();
      reg1_in = 32'h1000; reg2_in = 32'hDEAD_BEEF; I_in = 1; shifter_operand = 12'h4FF;
      alu_cmd = ALU_ADD; mem_read_in = 1; dest_in = 4'd7; wb_en_in = 1;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h14FF) $display("FAIL ldr_addr got %h exp 000014FF", alu_res_out); else pass_cnt++;
      chk_cnt++; if (mem_read_out !== 1'b1 || mem_write_out !== 1'b0) $display("FAIL ldr_ctrl got %b%b exp 10", mem_read_out, mem_write_out); else pass_cnt++;
      reg1_in = 32'h2000; I_in = 0; shifter_operand = 12'h004; mem_read_in = 0; mem_write_in = 1; wb_en_in = 0;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h2004) $display("FAIL str_addr got %h exp 00002004", alu_res_out); else pass_cnt++;
      chk_cnt++; if (st_val_out !== 32'hDEAD_BEEF) $display("FAIL str_stval got %h exp DEADBEEF", st_val_out); else pass_cnt++;
      chk_cnt++; if (mem_write_out !== 1'b1 || wb_en_out !== 1'b0) $display("FAIL str_ctrl got %b%b exp 10", mem_write_out, wb_en_out); else pass_cnt++;
   endtask

   task automatic test_branch();
      clear_inputs();
      branch_in = 1; pc_in = 32'h100; b_signed_imm = 24'hFFFFFE;
      #1;
      chk_cnt++; if (branch_taken !== 1'b1) $display("FAIL br_taken got %b exp 1", branch_taken); else pass_cnt++;
      chk_cnt++; if (branch_addr !== 32'hF8) $display("FAIL br_addr_neg got %h exp 000000F8", branch_addr); else pass_cnt++;
      freeze = 1; pc_in = 32'h200; b_signed_imm = 24'h000010;
      #1;
      chk_cnt++; if (branch_addr !== 32'h240) $display("FAIL br_addr_frz got %h exp 00000240", branch_addr); else pass_cnt++;
      branch_in = 0;
      #1;
      chk_cnt++; if (branch_taken !== 1'b0) $display("FAIL br_not_taken got %b exp 0", branch_taken); else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      reg1_in = 32'h55; reg2_in = 32'h1; alu_cmd = ALU_ADD; status_en = 1; dest_in = 4'd4; wb_en_in = 1;
      tick();
      freeze = 1;
      #2 rst = 1'b1;
      #1;
      chk_cnt++; if (alu_res_out !== 32'h0 || st_val_out !== 32'h0) $display("FAIL midrst_data got %h/%h exp 0/0", alu_res_out, st_val_out); else pass_cnt++;
      chk_cnt++; if ({dest_out, wb_en_out, mem_read_out, mem_write_out} !== 7'h0 || sr_out !== 4'h0)
         $display("FAIL midrst_ctrl got %b/%b exp 0/0", {dest_out, wb_en_out, mem_read_out, mem_write_out}, sr_out); else pass_cnt++;
      tick();
      rst = 1'b0; freeze = 0; reg1_in = 2; reg2_in = 3; dest_in = 4'd5;
      tick();
      chk_cnt++; if (alu_res_out !== 32'd5 || dest_out !== 4'd5) $display("FAIL post_rst got %h/%h exp 5/5", alu_res_out, dest_out); else pass_cnt++;
   endtask

`ifdef FORWARDING_EN
   task automatic test_forwarding();
      clear_inputs();
      sel_src1 = FWD_MEM; mem_fwd_val = 32'h10; reg1_in = 32'hAAAA; reg2_in = 2; alu_cmd = ALU_ADD;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h12) $display("FAIL fwd_src1 got %h exp 12", alu_res_out); else pass_cnt++;
      sel_src1 = FWD_REG; reg1_in = 1; sel_src2 = FWD_WB; wb_fwd_val = 32'h7;
      tick();
      chk_cnt++; if (alu_res_out !== 32'h8 || st_val_out !== 32'h7) $display("FAIL fwd_src2 got %h/%h exp 8/7", alu_res_out, st_val_out); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_add_overflow();
      test_imm_rotate();
      test_shifts();
      test_sub_freeze();
      test_adc_sbc();
      test_logic_ops();
      test_mem_addr();
      test_branch();
      test_reset_mid();
`ifdef FORWARDING_EN
      test_forwarding();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset rst, asynchronous, active-high; clock clk.
REQ-002 SHALL have: freeze in 1 (hold all registers); pc_in in 32 (PC+4 of instruction); reg1_in, reg2_in in 32 (Rn, Rm values).
REQ-003 SHALL have: alu_cmd in 4; status_en, mem_read_in, mem_write_in, wb_en_in, branch_in, I_in in 1 each.
REQ-004 SHALL have: dest_in in 4; status_in in 4 (NZCV from pipe); shifter_operand in 12; b_signed_imm in 24.
REQ-005 SHALL have (FORWARDING_EN only): sel_src1, sel_src2 in 2; mem_fwd_val, wb_fwd_val in 32.
REQ-006 SHALL have outputs: branch_taken out 1; branch_addr out 32; sr_out out 4 (NZCV to ID).
REQ-007 SHALL have registered outputs: alu_res_out 32; st_val_out 32; dest_out 4; wb_en_out, mem_read_out, mem_write_out 1.

Function
REQ-008 ALU codes SHALL be: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000; LDR/STR use ADD; undefined codes give 0, flags unchanged.
REQ-009 val2: if mem_read_in|mem_write_in -> zero-extended shifter_operand[11:0].
REQ-010 val2: else if I_in -> {24'b0, imm8[7:0]} rotated right by 2*rotate[11:8].
REQ-011 val2: else reg2 shifted by shift_imm[11:7], type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR; shift 0 -> unchanged.
REQ-012 Arithmetic SHALL be 33-bit; C = bit 32 for ADD/ADC; C = NOT borrow for SUB/SBC; ADC adds status_in C; SBC subtracts NOT C.
REQ-013 V SHALL be signed overflow for ADD/ADC/SUB/SBC, else 0; C = 0 for logic/MOV ops; N = res[31]; Z = (res == 0).
REQ-014 Status register SHALL load NZCV at clk edge when status_en=1 and freeze=0; sr_out is its current value.
REQ-015 branch_taken = branch_in combinationally; branch_addr = pc_in + (sign-extended imm24 << 2), modulo 2^32.
REQ-016 EXE/MEM register SHALL capture alu result, src2 operand value, dest, wb_en, mem_read, mem_write each edge with freeze=0; 1-cycle latency.
REQ-017 freeze=1 SHALL hold EXE/MEM and status register unchanged; branch outputs stay combinational.
REQ-018 Simultaneous freeze and status_en SHALL leave SR unchanged.

Reset
REQ-019 rst=1 SHALL clear asynchronously all registered outputs and SR to 0, regardless of freeze.
REQ-020 After rst deasserts, first capture SHALL occur on next rising clk edge.

Configuration
REQ-021 With FORWARDING_EN defined: src1/src2 SHALL select 00 reg, 01 mem_fwd_val, 10 wb_fwd_val, 11 reg; forwarded src2 drives val2 and st_val_out.
REQ-022 Without FORWARDING_EN: ports of REQ-005 SHALL be absent; reg1_in/reg2_in used directly.

Structure
REQ-023 Shared package SHALL hold ALU command constants, shift-type constants, and forwarding select encodings.
REQ-024 val2 generation SHALL be sub-module val2_gen (combinational); ALU and registers in exe_stage.

Verification
REQ-025 ADD reg1=0x7FFFFFFF, val2=1, status_en=1 -> alu_res 0x80000000; SR N=1 Z=0 C=0 V=1 next edge.
REQ-026 I_in=1, shifter 0x4FF (rot 4, imm 0xFF), MOV -> alu_res 0xFF000000.
REQ-027 SUB 5-5, status_en=1 -> res 0, SR Z=1 C=1; then freeze=1 with ADD 1+1 -> outputs and SR hold.
REQ-028 branch_in=1, pc_in 0x100, imm24 0xFFFFFE -> branch_taken=1, branch_addr 0xF8.
REQ-029 rst pulse mid-stream with freeze=1 -> all registered outputs and SR 0 immediately.
REQ-030 FORWARDING_EN, sel_src1=01, mem_fwd_val=0x10, ADD val2=2 -> alu_res 0x12.
